// File: rtl/motor_cmd_deframer.sv
// rtl/motor_cmd_deframer.sv - deframes UART bytes into atomic per-motor speed commands
//
// Frame: SYNC_BYTE, NUM_CH payload bytes (channel 0 first), 8-bit additive checksum.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   rx_data    received byte
//   rx_valid   one-cycle strobe, rx_data valid
//   cmd_out    channel k speed in bits [8k+7:8k], registered
//   cmd_update one-cycle pulse, cmd_out just loaded from a valid frame
//   frame_err  one-cycle pulse, checksum mismatch
//   gap_err    one-cycle pulse, frame aborted by inter-byte timeout
//   link_ok    high while a valid frame has committed within STALE_CYC cycles
module motor_cmd_deframer #(
    parameter int         NUM_CH    = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         GAP_CYC   = 50000,
    parameter int         STALE_CYC = 5000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [8*NUM_CH-1:0]   cmd_out,
    output logic                  cmd_update,
    output logic                  frame_err,
    output logic                  gap_err,
    output logic                  link_ok
);

    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int GAP_W   = $clog2(GAP_CYC + 1);
    localparam int STALE_W = $clog2(STALE_CYC + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CH - 1);
    // Counters fire one count early so the abort lands in the cycle the
    // limit is reached and the outcome is visible the following cycle.
    localparam logic [GAP_W-1:0]   GAP_LIM   = GAP_W'(GAP_CYC - 1);
    localparam logic [STALE_W-1:0] STALE_LIM = STALE_W'(STALE_CYC - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYC);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [7:0]           sum;
    logic [8*NUM_CH-1:0]  shadow;
    logic [GAP_W-1:0]     gap_cnt;
    logic [STALE_W-1:0]   stale_cnt;
    logic                 armed;
    logic                 commit;

    // Checksum byte accepted and matching in this cycle.
    assign commit = (state == CHECK) && rx_valid && (rx_data == sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= HUNT;
            idx        <= '0;
            sum        <= '0;
            shadow     <= '0;
            gap_cnt    <= '0;
            stale_cnt  <= '0;
            armed      <= 1'b0;
            cmd_out    <= '0;
            cmd_update <= 1'b0;
            frame_err  <= 1'b0;
            gap_err    <= 1'b0;
            link_ok    <= 1'b0;
        end else begin
            cmd_update <= 1'b0;
            frame_err  <= 1'b0;
            gap_err    <= 1'b0;

            case (state)
                HUNT: begin
                    gap_cnt <= '0;
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state <= PAYLOAD;
                        idx   <= '0;
                        sum   <= '0;
                    end
                end

                PAYLOAD: begin
                    if (rx_valid) begin
                        // SYNC_BYTE is ordinary data here; no resync inside a frame.
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (idx == IDX_W'(k)) begin
                                shadow[8*k +: 8] <= rx_data;
                            end
                        end
                        sum     <= sum + rx_data;
                        gap_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state <= CHECK;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (gap_cnt == GAP_LIM) begin
                        gap_err <= 1'b1;
                        gap_cnt <= '0;
                        state   <= HUNT;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                CHECK: begin
                    if (rx_valid) begin
                        gap_cnt <= '0;
                        state   <= HUNT;
                        if (commit) begin
                            cmd_out    <= shadow;
                            cmd_update <= 1'b1;
                            link_ok    <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (gap_cnt == GAP_LIM) begin
                        gap_err <= 1'b1;
                        gap_cnt <= '0;
                        state   <= HUNT;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state   <= HUNT;
                    gap_cnt <= '0;
                end
            endcase

            // Stale-link watchdog: idle until the first commit, then counts
            // cycles since the last commit and zeroes the outputs once.
            // A commit in the threshold cycle takes the first branch and wins.
            if (commit) begin
                stale_cnt <= '0;
                armed     <= 1'b1;
            end else if (armed && (stale_cnt != STALE_MAX)) begin
                stale_cnt <= stale_cnt + STALE_W'(1);
                if (stale_cnt == STALE_LIM) begin
                    cmd_out <= '0;
                    link_ok <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_deframer.sv
// tb/tb_motor_cmd_deframer.sv - self-checking bench for motor_cmd_deframer
module tb_motor_cmd_deframer;

    localparam int         NUM_CH = 4;
    localparam logic [7:0] SYNC   = 8'hA5;
    localparam int         GAP    = 20;
    localparam int         STALE  = 100;
    localparam int         W      = 8 * NUM_CH;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic [7:0]   rx_data  = 8'h00;
    logic         rx_valid = 1'b0;
    logic [W-1:0] cmd_out;
    logic         cmd_update;
    logic         frame_err;
    logic         gap_err;
    logic         link_ok;

    motor_cmd_deframer #(
        .NUM_CH    (NUM_CH),
        .SYNC_BYTE (SYNC),
        .GAP_CYC   (GAP),
        .STALE_CYC (STALE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .cmd_out    (cmd_out),
        .cmd_update (cmd_update),
        .frame_err  (frame_err),
        .gap_err    (gap_err),
        .link_ok    (link_ok)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: frame bytes in a queue, timeouts from absolute cycle stamps.
    bit           in_frame    = 1'b0;
    logic [7:0]   fbuf[$];
    bit           armed       = 1'b0;
    int           last_byte   = 0;
    int           last_commit = 0;
    logic [W-1:0] m_cmd       = '0;
    bit           m_upd = 1'b0, m_ferr = 1'b0, m_gerr = 1'b0, m_link = 1'b0;

    // Expectations for the cycle currently on the DUT outputs.
    logic [W-1:0] e_cmd = '0;
    bit           e_upd = 1'b0, e_ferr = 1'b0, e_gerr = 1'b0, e_link = 1'b0;
    bit           check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("cmd_out",    64'(cmd_out),    64'(e_cmd));
            check("cmd_update", 64'(cmd_update), 64'(e_upd));
            check("frame_err",  64'(frame_err),  64'(e_ferr));
            check("gap_err",    64'(gap_err),    64'(e_gerr));
            check("link_ok",    64'(link_ok),    64'(e_link));
        end
    end

    // Outcome of one input cycle, as seen on the outputs in the next cycle.
    task automatic model_step(input bit v, input logic [7:0] d, input bit rn);
        logic [7:0] s;
        bit         committed;
        m_upd  = 1'b0;
        m_ferr = 1'b0;
        m_gerr = 1'b0;
        committed = 1'b0;
        if (!rn) begin
            in_frame = 1'b0;
            fbuf.delete();
            armed  = 1'b0;
            m_cmd  = '0;
            m_link = 1'b0;
            return;
        end
        if (in_frame) begin
            if (v) begin
                fbuf.push_back(d);
                last_byte = cyc;
                if (fbuf.size() == NUM_CH + 1) begin
                    s = 8'h00;
                    for (int k = 0; k < NUM_CH; k++) s = s + fbuf[k];
                    if (s == fbuf[NUM_CH]) begin
                        for (int k = 0; k < NUM_CH; k++) m_cmd[8*k +: 8] = fbuf[k];
                        m_upd       = 1'b1;
                        m_link      = 1'b1;
                        armed       = 1'b1;
                        last_commit = cyc;
                        committed   = 1'b1;
                    end else begin
                        m_ferr = 1'b1;
                    end
                    in_frame = 1'b0;
                    fbuf.delete();
                end
            end else if (cyc - last_byte == GAP) begin
                m_gerr   = 1'b1;
                in_frame = 1'b0;
                fbuf.delete();
            end
        end else if (v && d == SYNC) begin
            in_frame  = 1'b1;
            last_byte = cyc;
        end
        if (armed && !committed && (cyc - last_commit == STALE)) begin
            m_cmd  = '0;
            m_link = 1'b0;
        end
    endtask

    task automatic tick(input bit v, input logic [7:0] d, input bit rn);
        rx_valid = v;
        rx_data  = d;
        rst_n    = rn;
        model_step(v, d, rn);
        @(posedge clk);
        #1;
        e_cmd  = m_cmd;
        e_upd  = m_upd;
        e_ferr = m_ferr;
        e_gerr = m_gerr;
        e_link = m_link;
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        tick(1'b1, d, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1);
    endtask

    function automatic logic [7:0] csum(input logic [W-1:0] pl);
        logic [7:0] s = 8'h00;
        for (int k = 0; k < NUM_CH; k++) s = s + pl[8*k +: 8];
        return s;
    endfunction

    task automatic frame(input logic [W-1:0] pl, input logic [7:0] ck);
        send(SYNC);
        for (int k = 0; k < NUM_CH; k++) send(pl[8*k +: 8]);
        send(ck);
    endtask

    // Hand-computed expectation checked against both the DUT and the model.
    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] mdl,
                       input logic [63:0] want);
        check({name, "_dut"}, act, want);
        check({name, "_model"}, mdl, want);
    endtask

    initial begin
        logic [W-1:0] pl;
        logic [7:0]   ck;
        int           gp;

        tick(1'b0, 8'h00, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check_en = 1'b1;
        lit("reset_cmd", 64'(cmd_out), 64'(e_cmd), 64'h0);
        lit("reset_link", 64'(link_ok), 64'(e_link), 64'h0);

        // Valid frame; cmd_update in the cycle right after the checksum byte.
        idle(2);
        frame(32'h40302010, 8'hA0);
        lit("valid_cmd", 64'(cmd_out), 64'(e_cmd), 64'h40302010);
        lit("valid_upd", 64'(cmd_update), 64'(e_upd), 64'h1);
        lit("valid_link", 64'(link_ok), 64'(e_link), 64'h1);
        idle(1);
        lit("valid_upd_once", 64'(cmd_update), 64'(e_upd), 64'h0);

        // Bad checksum.
        frame(32'h44332211, 8'h00);
        lit("bad_ferr", 64'(frame_err), 64'(e_ferr), 64'h1);
        lit("bad_cmd", 64'(cmd_out), 64'(e_cmd), 64'h40302010);
        lit("bad_upd", 64'(cmd_update), 64'(e_upd), 64'h0);

        // Garbage, embedded sync; A5+01+02+03 = AB, so 4E is rejected, AB accepted.
        send(8'h00); send(8'hFF); send(8'h3C);
        lit("garbage_ferr", 64'(frame_err), 64'(e_ferr), 64'h0);
        frame(32'h030201A5, 8'h4E);
        lit("embed_bad_ferr", 64'(frame_err), 64'(e_ferr), 64'h1);
        send(8'h00); send(8'hFF); send(8'h3C);
        frame(32'h030201A5, 8'hAB);
        lit("embed_cmd", 64'(cmd_out), 64'(e_cmd), 64'h030201A5);

        // Gap timeout after the 20th idle cycle.
        send(SYNC); send(8'h10); send(8'h20);
        idle(GAP - 1);
        lit("gap_early", 64'(gap_err), 64'(e_gerr), 64'h0);
        idle(1);
        lit("gap_err", 64'(gap_err), 64'(e_gerr), 64'h1);
        frame(32'h01010101, 8'h04);
        lit("gap_recover", 64'(cmd_out), 64'(e_cmd), 64'h01010101);

        // Byte arriving in the limit cycle is accepted.
        send(SYNC); idle(GAP - 1); send(8'h10); idle(GAP - 1);
        send(8'h20); send(8'h30); send(8'h40); send(8'hA0);
        lit("gap_edge_cmd", 64'(cmd_out), 64'(e_cmd), 64'h40302010);

        // Stale watchdog.
        idle(STALE - 1);
        lit("stale_early", 64'(link_ok), 64'(e_link), 64'h1);
        idle(1);
        lit("stale_link", 64'(link_ok), 64'(e_link), 64'h0);
        lit("stale_cmd", 64'(cmd_out), 64'(e_cmd), 64'h0);
        lit("stale_upd", 64'(cmd_update), 64'(e_upd), 64'h0);
        frame(32'h01010101, 8'h04);
        lit("stale_restore", 64'(link_ok), 64'(e_link), 64'h1);

        // Commit lands exactly on the stale threshold cycle.
        idle(STALE - NUM_CH - 2);
        frame(32'h04030201, 8'h0A);
        lit("stale_tie_link", 64'(link_ok), 64'(e_link), 64'h1);
        lit("stale_tie_cmd", 64'(cmd_out), 64'(e_cmd), 64'h04030201);

        // Reset mid-frame discards the partial frame.
        send(SYNC); send(8'h10); send(8'h20);
        tick(1'b0, 8'h00, 1'b0);
        lit("rst_cmd", 64'(cmd_out), 64'(e_cmd), 64'h0);
        lit("rst_link", 64'(link_ok), 64'(e_link), 64'h0);
        send(8'h30); send(8'h40); send(8'hA0);
        lit("rst_no_commit", 64'(cmd_update), 64'(e_upd), 64'h0);
        idle(3);

        // Randomized traffic.
        for (int it = 0; it < 300; it++) begin
            int sel = $urandom_range(0, 99);
            if (sel < 2) begin
                tick(1'b0, 8'h00, 1'b0);
            end else if (sel < 7) begin
                idle($urandom_range(STALE - 6, STALE + 6));
            end else if (sel < 15) begin
                for (int j = 0; j < 3; j++) send(8'($urandom));
            end else begin
                pl = W'($urandom);
                ck = ($urandom_range(0, 4) == 0) ? 8'($urandom) : csum(pl);
                for (int b = 0; b < NUM_CH + 2; b++) begin
                    if (b == 0)            send(SYNC);
                    else if (b <= NUM_CH)  send(pl[8*(b-1) +: 8]);
                    else                   send(ck);
                    if (b < NUM_CH + 1) begin
                        gp = ($urandom_range(0, 9) == 0) ? $urandom_range(GAP - 3, GAP + 1)
                                                         : $urandom_range(0, 2);
                        idle(gp);
                    end
                end
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
            end
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
